// File: rtl/osd_ctm_sampler.sv
// Core-trace event sampler: timestamps privilege changes, traps and (optionally, with
// OSD_CTM_SAMPLER_JUMP_EN) taken jumps into a FWFT FIFO; back-pressure drops become overflow records.
module osd_ctm_sampler #(
  parameter int TS_WIDTH   = 32,
  parameter int ADDR_WIDTH = 64,
  parameter int FIFO_DEPTH = 8,
  parameter int OVF_WIDTH  = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               enable,
  input  logic [2:0]                         event_mask,
  input  logic                               trace_valid,
  input  logic [1:0]                         trace_prv,
  input  logic                               trace_trap,
  input  logic                               trace_xcpt,
  input  logic                               trace_jal,
  input  logic                               trace_jalr,
  input  logic                               trace_br_taken,
  input  logic [ADDR_WIDTH-1:0]              trace_npc,
  output logic [4+ADDR_WIDTH+TS_WIDTH-1:0]   out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [OVF_WIDTH-1:0]               drop_count
);

  localparam int REC_W = 4 + ADDR_WIDTH + TS_WIDTH;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

`ifdef OSD_CTM_SAMPLER_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    KIND_PRV  = 2'd0,
    KIND_TRAP = 2'd1,
    KIND_JUMP = 2'd2,
    KIND_OVF  = 2'd3
  } kind_t;

  logic [TS_WIDTH-1:0]  ts_reg;
  logic [1:0]           prv_reg;
  logic [OVF_WIDTH-1:0] drop_reg, drop_next;
  logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]     count_reg;
  logic [REC_W-1:0]     mem [FIFO_DEPTH];

  logic       trap_hit, prv_hit, jump_hit, cand;
  kind_t      cand_kind;
  logic       full, push, pop;
  logic [REC_W-1:0] push_data;

  assign trap_hit = trace_valid & enable & event_mask[1] & (trace_trap | trace_xcpt);
  assign prv_hit  = trace_valid & enable & event_mask[0] & (trace_prv != prv_reg);
  // Jump inputs stay referenced in both builds; JUMP_EN alone decides whether kind 2 exists.
  assign jump_hit = JUMP_EN & trace_valid & enable & event_mask[2]
                  & (trace_jal | trace_jalr | trace_br_taken);
  assign cand     = trap_hit | prv_hit | jump_hit;

  assign full      = (count_reg == CNT_W'(FIFO_DEPTH));
  assign out_valid = (count_reg != '0);
  assign pop       = out_valid & out_ready;

  always_comb begin
    cand_kind = KIND_JUMP;
    if (trap_hit)      cand_kind = KIND_TRAP;
    else if (prv_hit)  cand_kind = KIND_PRV;
  end

  // Pending drops are reported before any new event; fullness uses registered occupancy only.
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    drop_next = drop_reg;
    if ((drop_reg != '0) && !full) begin
      push      = 1'b1;
      push_data = {KIND_OVF, prv_reg, ADDR_WIDTH'(drop_reg), ts_reg};
      drop_next = cand ? OVF_WIDTH'(1) : '0;
    end else if (cand && !full) begin
      push      = 1'b1;
      push_data = {cand_kind, trace_prv, trace_npc, ts_reg};
    end else if (cand) begin
      drop_next = (drop_reg == '1) ? drop_reg : drop_reg + OVF_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_reg     <= '0;
      prv_reg    <= 2'b11;
      drop_reg   <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      ts_reg   <= ts_reg + TS_WIDTH'(1);
      drop_reg <= drop_next;
      if (trace_valid) prv_reg <= trace_prv;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= push_data;
  end

  // Storage is not reset, so the head is masked while empty.
  assign out_data   = out_valid ? mem[rd_ptr_reg] : '0;
  assign drop_count = drop_reg;

endmodule

// File: tb/tb_osd_ctm_sampler.sv
// Randomized and directed bench for osd_ctm_sampler against a queue-based reference model;
// kind-2 expectations follow OSD_CTM_SAMPLER_JUMP_EN.
module tb_osd_ctm_sampler;
  localparam int TSW = 32, AW = 64, DEPTH = 8, OW = 4, RW = 4 + AW + TSW;
`ifdef OSD_CTM_SAMPLER_JUMP_EN
  localparam bit JUMP = 1'b1;
`else
  localparam bit JUMP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic [2:0] event_mask;
  logic trace_valid, trace_trap, trace_xcpt, trace_jal, trace_jalr, trace_br_taken;
  logic [1:0] trace_prv;
  logic [AW-1:0] trace_npc;
  logic [RW-1:0] out_data;
  logic out_valid, out_ready;
  logic [OW-1:0] drop_count;

  osd_ctm_sampler #(.TS_WIDTH(TSW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .OVF_WIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .event_mask(event_mask),
    .trace_valid(trace_valid), .trace_prv(trace_prv), .trace_trap(trace_trap),
    .trace_xcpt(trace_xcpt), .trace_jal(trace_jal), .trace_jalr(trace_jalr),
    .trace_br_taken(trace_br_taken), .trace_npc(trace_npc), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [RW-1:0] q[$];
  int unsigned drop_m;
  logic [1:0] prv_m;
  logic [TSW-1:0] ts_m;
  int checks = 0, passed = 0, fails = 0;
  int kind2_seen = 0;

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    trace_valid = 0; trace_trap = 0; trace_xcpt = 0;
    trace_jal = 0; trace_jalr = 0; trace_br_taken = 0;
  endtask

  task automatic model_reset();
    q.delete(); drop_m = 0; prv_m = 2'b11; ts_m = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", RW'(out_valid), RW'(1'b0));
    check("rst_out_data", out_data, '0);
    check("rst_drop_count", RW'(drop_count), '0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One clock: predict from the rules, advance the DUT, compare.
  task automatic step();
    bit cand, full, pop, do_push;
    logic [1:0] kind;
    logic [RW-1:0] rec;
    cand = 0; kind = 0; do_push = 0; rec = '0;
    if (trace_valid && enable) begin
      if (event_mask[1] && (trace_trap || trace_xcpt)) begin cand = 1; kind = 2'd1; end
      else if (event_mask[0] && trace_prv != prv_m) begin cand = 1; kind = 2'd0; end
      else if (JUMP && event_mask[2] && (trace_jal || trace_jalr || trace_br_taken)) begin
        cand = 1; kind = 2'd2;
      end
    end
    full = (q.size() == DEPTH);
    pop  = (q.size() != 0) && out_ready;
    if (drop_m != 0 && !full) begin
      do_push = 1; rec = {2'd3, prv_m, AW'(drop_m), ts_m};
      drop_m = cand ? 1 : 0;
    end else if (cand && !full) begin
      do_push = 1; rec = {kind, trace_prv, trace_npc, ts_m};
    end else if (cand) begin
      drop_m = (drop_m >= (2**OW - 1)) ? (2**OW - 1) : drop_m + 1;
    end
    if (out_valid && out_ready) begin
      if (out_data[RW-1 -: 2] == 2'd2) kind2_seen++;
      $display("t=%0t pop kind=%0d prv=%0d payload=%h ts=%0d", $time, out_data[RW-1 -: 2],
               out_data[RW-3 -: 2], out_data[TSW +: AW], out_data[TSW-1:0]);
    end
    @(posedge clk); #1;
    if (pop) void'(q.pop_front());
    if (do_push) q.push_back(rec);
    ts_m = ts_m + 1'b1;
    if (trace_valid) prv_m = trace_prv;
    check("out_valid", RW'(out_valid), RW'(q.size() != 0));
    check("out_data", out_data, (q.size() != 0) ? q[0] : '0);
    check("drop_count", RW'(drop_count), RW'(drop_m));
  endtask

  task automatic trap_event(input logic [AW-1:0] npc);
    trace_valid = 1; trace_trap = 1; trace_npc = npc;
    step();
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b1; enable = 0; event_mask = 0; out_ready = 0;
    trace_prv = 2'b11; trace_npc = '0;
    idle_inputs();
    model_reset();
    #1;
    do_reset();

    // Privilege change, then a repeated retire at the same level
    enable = 1; event_mask = 3'b001; out_ready = 1;
    repeat (4) step();
    trace_valid = 1; trace_prv = 2'b00; trace_npc = 64'h1000;
    step();
    check("prv_rec_kind", RW'(out_data[RW-1 -: 2]), RW'(0));
    trace_npc = 64'h1004;
    step();
    idle_inputs();
    step();
    check("prv_no_repeat", RW'(out_valid), RW'(0));

    // Trap coincident with privilege change: only the trap survives
    event_mask = 3'b011; out_ready = 0;
    trace_valid = 1; trace_trap = 1; trace_prv = 2'b01; trace_npc = 64'h2000;
    step();
    idle_inputs();
    check("prio_kind", RW'(out_data[RW-1 -: 2]), RW'(1));
    check("prio_drop", RW'(drop_count), RW'(0));
    out_ready = 1; step(); out_ready = 0;

    // Overflow: 11 events into 8 slots, then one pop releases the overflow record
    event_mask = 3'b010;
    for (int i = 0; i < 11; i++) trap_event(64'h3000 + AW'(i));
    check("ovf_drop3", RW'(drop_count), RW'(3));
    out_ready = 1; step(); out_ready = 0;
    step();
    check("ovf_drop0", RW'(drop_count), RW'(0));

    // Coincident overflow push and new event
    trace_valid = 1; trace_trap = 1; trace_npc = 64'h4000;
    out_ready = 1; step(); out_ready = 0;
    step();
    idle_inputs();
    check("coinc_drop1", RW'(drop_count), RW'(1));

    // Saturation of the 4-bit drop counter
    for (int i = 0; i < 20; i++) trap_event(64'h5000 + AW'(i));
    check("sat_drop15", RW'(drop_count), RW'(15));
    out_ready = 1;
    repeat (12) step();

    // Asynchronous reset mid-stream
    out_ready = 0;
    for (int i = 0; i < 10; i++) trap_event(64'h6000 + AW'(i));
    do_reset();
    step();

    // Taken branches: kind 2 only when the jump feature is built in
    event_mask = 3'b100; out_ready = 1; kind2_seen = 0;
    for (int i = 0; i < 10; i++) begin
      trace_valid = 1; trace_br_taken = 1; trace_prv = prv_m; trace_npc = 64'h7000 + AW'(4 * i);
      step();
      idle_inputs();
    end
    repeat (3) step();
    check("jump_records", RW'(kind2_seen), RW'(JUMP ? 10 : 0));

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      enable = ($urandom_range(0, 7) != 0);
      event_mask = 3'($urandom);
      trace_valid = $urandom_range(0, 1);
      trace_prv = 2'($urandom);
      trace_trap = ($urandom_range(0, 5) == 0);
      trace_xcpt = ($urandom_range(0, 7) == 0);
      trace_jal = $urandom_range(0, 1);
      trace_jalr = ($urandom_range(0, 3) == 0);
      trace_br_taken = $urandom_range(0, 1);
      trace_npc = {32'($urandom), 32'($urandom)};
      out_ready = ($urandom_range(0, 3) != 0) ^ (i % 100 > 70);
      step();
    end
    idle_inputs();
    out_ready = 1;
    repeat (10) step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/osd_ctm_sampler.md
# osd_ctm_sampler

Parametrised core-trace event sampler for the CTM datapath. It timestamps selected core events into a bounded internal FIFO and presents them as a valid/ready record stream to the trace packetizer:
- privilege-mode changes
- traps/exceptions
- optionally, taken control-flow transfers

Drops caused by back-pressure are counted and reported in-band as overflow records.

## Interface
- TS_WIDTH, 32: timestamp counter width.
- ADDR_WIDTH, 64: PC width.
- FIFO_DEPTH, 8: record buffer entries; power of two, ≥2.
- OVF_WIDTH, 16: drop counter width, ≤ADDR_WIDTH.
- clk  in  1  clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  gates event capture only.
- event_mask  in  3  bit0 privilege change, bit1 trap/xcpt, bit2 jump/branch.
- trace_valid  in  1  retire strobe; all trace_* qualified by it.
- trace_prv  in  2  privilege level of retired instruction.
- trace_trap, trace_xcpt  in  1 each  trap / exception retire.
- trace_jal, trace_jalr, trace_br_taken  in  1 each  control-flow retire.
- trace_npc  in  ADDR_WIDTH  next PC.
- out_data  out  4+ADDR_WIDTH+TS_WIDTH  record {kind[1:0], prv[1:0], payload, timestamp}.
- out_valid  out  1  record available.
- out_ready  in  1  consumer accepts.
- drop_count  out  OVF_WIDTH  current unreported drop count.

## Operation
- timestamp: free-running, +1 every cycle regardless of enable, wraps modulo 2^TS_WIDTH. Reset value 0.
- prv_reg: loads trace_prv on every trace_valid, regardless of enable. Reset value 2'b11.
- Candidate event in cycle N requires trace_valid & enable, and is one of:
  - kind 1: trap/xcpt, when mask[1] & (trace_trap | trace_xcpt).
  - kind 0: privilege change, when mask[0] & (trace_prv != prv_reg).
  - kind 2: jump, when mask[2] & (jal | jalr | br_taken).
- Priority is 1 > 0 > 2. At most one record is produced per cycle; lower-priority coincident events are discarded and not counted.
- Record fields:
  - prv = trace_prv.
  - timestamp = counter value in cycle N.
  - payload = trace_npc for kinds 0–2.
- Overflow record (kind 3): prv = prv_reg, payload = drop counter zero-extended.
- Push arbitration each cycle, with full evaluated on the registered occupancy (a same-cycle pop does not free space):
  - If drop_count≠0 and not full: push the overflow record. drop_count becomes 1 if a candidate event exists this cycle, else 0.
  - Else if candidate and not full: push the event record.
  - Else if candidate and full: drop it. drop_count increments, saturating at all-ones.
- Overflow records are emitted even when enable=0.
- FIFO behaviour:
  - First-word-fall-through from registered storage.
  - out_data shows the head entry; pop on out_valid & out_ready.
  - Pointers wrap modulo FIFO_DEPTH.
  - Occupancy counter ranges 0..FIFO_DEPTH.
- Reset mid-operation: FIFO is emptied immediately, drop_count=0, timestamp=0, prv_reg=3. Pending records are lost.

## Timing
- Reset values: out_valid=0, out_data=0, drop_count=0.
- Event in cycle N with FIFO empty: out_valid=1 from cycle N+1.
- Handshake:
  - out_data is stable while out_valid & !out_ready.
  - out_valid never deasserts without a pop.
- Simultaneous push and pop when not empty and not full: occupancy unchanged, both succeed.
- Full for FIFO_DEPTH entries. Occupancy drops to FIFO_DEPTH-1 the cycle after a pop; the first push is accepted in that cycle.
- drop_count updates registered, visible at N+1.

## Configuration
- OSD_CTM_SAMPLER_JUMP_EN defined: kind 2 capture is active per event_mask[2].
- Not defined:
  - event_mask[2], trace_jal, trace_jalr and trace_br_taken are ignored.
  - kind 2 is never produced.
  - Port list is unchanged.

## Test plan
- Privilege change: reset, mask=3'b001, enable=1; trace_valid with prv=0 at timestamp 5 -> one record {kind 0, prv 0, npc, ts 5} with out_valid at cycle 6. A second retire with prv=0 produces nothing.
- Priority: trap plus privilege change in the same cycle with mask=3'b011 -> exactly one record, kind 1. drop_count stays 0.
- Overflow: out_ready=0, FIFO_DEPTH=8, 11 distinct events -> 8 records held, drop_count=3. Raise out_ready for one pop -> next push is the kind 3 record with payload 3, and drop_count=0.
- Saturation: OVF_WIDTH=4, 20 drops while full -> drop_count holds 15.
- Coincidence and reset: overflow record pushed in the same cycle as a new event -> drop_count=1, and the next free slot carries a kind 3 record with payload 1. Assert rst_n low asynchronously mid-stream -> out_valid=0 and drop_count=0 immediately.
- Macro: build without OSD_CTM_SAMPLER_JUMP_EN, mask=3'b100, 10 taken branches -> no records. With the macro defined -> 10 kind 2 records.
